// File: rtl/rank_cmd_dispatcher.sv
// rank_cmd_dispatcher: routes host commands into four per-rank FWFT FIFOs and
// records the rank of every accepted READ in a read-order queue.
//
// Host command layout (cmd_i, 37 bits, MSB first):
//    [36:35] rank_num | [34] r_w (1 = READ, 0 = WRITE) | [33:32] reserved |
//    [31:16] row_addr | [15:14] burst_length | [13] auto_precharge |
//    [12:3] col_addr  | [2:0] bank_addr
// The per-rank command (35 bits) is cmd_i with rank_num removed, i.e. cmd_i[34:0].
module rank_cmd_dispatcher #(
   parameter int FIFO_DEPTH  = 4,
   parameter int ORDER_DEPTH = 16,
   localparam int CMD_W  = 35,
   localparam int USER_W = 37,
   localparam int FCW    = $clog2(FIFO_DEPTH) + 1,
   localparam int OCW    = $clog2(ORDER_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid_i,
   input  logic [USER_W-1:0]    cmd_i,
   output logic                 cmd_ready_o,
   output logic [3:0]           rank_cmd_valid_o,
   output logic [4*CMD_W-1:0]   rank_cmd_o,
   input  logic [3:0]           rank_cmd_ready_i,
   output logic [4*FCW-1:0]     rank_fifo_cnt_o,
   output logic                 rd_order_valid_o,
   output logic [1:0]           rd_order_rank_o,
   input  logic                 rd_order_pop_i
);

   localparam int FPW = FCW - 1;
   localparam int OPW = OCW - 1;

   logic [1:0]       sel_rank;
   logic             is_read;
   logic [CMD_W-1:0] stripped;
   logic [3:0]       rank_full;
   logic             ord_full;
   logic             push;

   assign sel_rank = cmd_i[36:35];
   assign is_read  = cmd_i[34];
   assign stripped = cmd_i[CMD_W-1:0];

   // Ready only looks at registered occupancy, so a same-cycle pop never frees a slot.
   assign cmd_ready_o = ~rank_full[sel_rank] & (~is_read | ~ord_full);
   assign push        = cmd_valid_i & cmd_ready_o;

   for (genvar r = 0; r < 4; r++) begin : g_rank
      logic [CMD_W-1:0] mem [FIFO_DEPTH];
      logic [FPW-1:0]   wr_ptr;
      logic [FPW-1:0]   rd_ptr;
      logic [FCW-1:0]   cnt;
      logic             push_r;
      logic             pop_r;

      assign push_r = push & (sel_rank == 2'(r));
      assign pop_r  = (cnt != '0) & rank_cmd_ready_i[r];

      // Pointer and occupancy update; pointers wrap naturally at the power-of-2 depth.
      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push_r) wr_ptr <= wr_ptr + FPW'(1);
            if (pop_r)  rd_ptr <= rd_ptr + FPW'(1);
            cnt <= cnt + FCW'(push_r) - FCW'(pop_r);
         end
      end

      // Storage write; contents need no reset because the head is masked when empty.
      always_ff @(posedge clk) begin
         if (!rst && push_r) mem[wr_ptr] <= stripped;
      end

      assign rank_full[r]                  = (cnt == FCW'(FIFO_DEPTH));
      assign rank_cmd_valid_o[r]           = (cnt != '0);
      assign rank_cmd_o[r*CMD_W +: CMD_W]  = (cnt != '0) ? mem[rd_ptr] : '0;
      assign rank_fifo_cnt_o[r*FCW +: FCW] = cnt;
   end

   logic [1:0]     ord_mem [ORDER_DEPTH];
   logic [OPW-1:0] ord_wr_ptr;
   logic [OPW-1:0] ord_rd_ptr;
   logic [OCW-1:0] ord_cnt;
   logic           ord_push;
   logic           ord_pop;

   assign ord_push = push & is_read;
   assign ord_pop  = rd_order_pop_i & (ord_cnt != '0);

   // Read-order queue pointers and occupancy; an empty-queue pop is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         ord_wr_ptr <= '0;
         ord_rd_ptr <= '0;
         ord_cnt    <= '0;
      end else begin
         if (ord_push) ord_wr_ptr <= ord_wr_ptr + OPW'(1);
         if (ord_pop)  ord_rd_ptr <= ord_rd_ptr + OPW'(1);
         ord_cnt <= ord_cnt + OCW'(ord_push) - OCW'(ord_pop);
      end
   end

   // Read-order storage write.
   always_ff @(posedge clk) begin
      if (!rst && ord_push) ord_mem[ord_wr_ptr] <= sel_rank;
   end

   assign ord_full         = (ord_cnt == OCW'(ORDER_DEPTH));
   assign rd_order_valid_o = (ord_cnt != '0);
   assign rd_order_rank_o  = (ord_cnt != '0) ? ord_mem[ord_rd_ptr] : 2'b00;

endmodule

// File: tb/tb_rank_cmd_dispatcher.sv
// Directed plus randomized bench for rank_cmd_dispatcher with a queue-based reference.
module tb_rank_cmd_dispatcher;

   localparam int FIFO_DEPTH  = 4;
   localparam int ORDER_DEPTH = 16;
   localparam int CMD_W       = 35;
   localparam int USER_W      = 37;
   localparam int FCW         = 3;

   logic                clk;
   logic                rst;
   logic                cmd_valid_i;
   logic [USER_W-1:0]   cmd_i;
   logic                cmd_ready_o;
   logic [3:0]          rank_cmd_valid_o;
   logic [4*CMD_W-1:0]  rank_cmd_o;
   logic [3:0]          rank_cmd_ready_i;
   logic [4*FCW-1:0]    rank_fifo_cnt_o;
   logic                rd_order_valid_o;
   logic [1:0]          rd_order_rank_o;
   logic                rd_order_pop_i;

   rank_cmd_dispatcher #(.FIFO_DEPTH(FIFO_DEPTH), .ORDER_DEPTH(ORDER_DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_i            (cmd_i),
      .cmd_ready_o      (cmd_ready_o),
      .rank_cmd_valid_o (rank_cmd_valid_o),
      .rank_cmd_o       (rank_cmd_o),
      .rank_cmd_ready_i (rank_cmd_ready_i),
      .rank_fifo_cnt_o  (rank_fifo_cnt_o),
      .rd_order_valid_o (rd_order_valid_o),
      .rd_order_rank_o  (rd_order_rank_o),
      .rd_order_pop_i   (rd_order_pop_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference state: plain queues in acceptance order
   logic [CMD_W-1:0] rq [4][$];
   logic [1:0]       oq [$];
   logic             last_ready;

   function automatic logic [USER_W-1:0] mk(input logic [1:0] rank, input logic rd,
                                            input logic [15:0] row, input logic [9:0] col,
                                            input logic [2:0] bank);
      return {rank, rd, 2'b00, row, 2'b01, 1'b0, col, bank};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      for (int r = 0; r < 4; r++) begin
         check($sformatf("rank%0d_valid", r), 64'(rank_cmd_valid_o[r]), 64'(rq[r].size() != 0));
         check($sformatf("rank%0d_head", r), 64'(rank_cmd_o[r*CMD_W +: CMD_W]),
               64'((rq[r].size() != 0) ? rq[r][0] : '0));
         check($sformatf("rank%0d_cnt", r), 64'(rank_fifo_cnt_o[r*FCW +: FCW]), 64'(rq[r].size()));
      end
      check("ord_valid", 64'(rd_order_valid_o), 64'(oq.size() != 0));
      check("ord_head", 64'(rd_order_rank_o), 64'((oq.size() != 0) ? oq[0] : 2'b00));
   endtask

   // one clock: check ready before the edge, advance the reference, check state after
   task automatic step();
      logic [1:0] rk;
      logic       rd;
      logic       exp_ready;
      logic       acc;
      #1;
      rk = cmd_i[36:35];
      rd = cmd_i[34];
      exp_ready = (rq[rk].size() < FIFO_DEPTH) && (!rd || (oq.size() < ORDER_DEPTH));
      last_ready = cmd_ready_o;
      if (!rst) check("cmd_ready", 64'(cmd_ready_o), 64'(exp_ready));
      acc = !rst && cmd_valid_i && exp_ready;
      @(posedge clk);
      #1;
      if (rst) begin
         for (int r = 0; r < 4; r++) rq[r].delete();
         oq.delete();
      end else begin
         for (int r = 0; r < 4; r++)
            if (rq[r].size() != 0 && rank_cmd_ready_i[r]) void'(rq[r].pop_front());
         if (rd_order_pop_i && oq.size() != 0) void'(oq.pop_front());
         if (acc) begin
            rq[rk].push_back(cmd_i[CMD_W-1:0]);
            if (rd) oq.push_back(rk);
         end
      end
      check_outputs();
   endtask

   logic [1:0] seq_ranks [7];
   logic       seq_rd    [7];
   logic [1:0] exp_ord   [4];

   initial begin
      rst = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_i = '0;
      rank_cmd_ready_i = 4'h0;
      rd_order_pop_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      check("post_reset_ready", 64'(cmd_ready_o), 64'd1);

      // single write to rank 2
      cmd_valid_i = 1'b1;
      cmd_i = mk(2'd2, 1'b0, 16'h01A5, 10'h03C, 3'd3);
      step();
      cmd_valid_i = 1'b0;
      check("wr_valid_vec", 64'(rank_cmd_valid_o), 64'h4);
      check("wr_fields", 64'(rank_cmd_o[2*CMD_W +: CMD_W]),
            64'({1'b0, 2'b00, 16'h01A5, 2'b01, 1'b0, 10'h03C, 3'd3}));
      check("wr_no_order", 64'(rd_order_valid_o), 64'd0);
      rank_cmd_ready_i = 4'hF;
      step();

      // fill rank 0 with its ready held low
      rank_cmd_ready_i = 4'hE;
      cmd_valid_i = 1'b1;
      for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
         cmd_i = mk(2'd0, 1'b0, 16'(16'h100 + i), 10'(i), 3'(i));
         step();
         if (i == FIFO_DEPTH) check("rank0_full_refuse", 64'(last_ready), 64'd0);
      end
      cmd_i = mk(2'd1, 1'b0, 16'h0777, 10'h011, 3'd1);
      step();
      check("rank1_while_rank0_full", 64'(last_ready), 64'd1);

      // full FIFO with pop: waiting command enters one cycle after the pop
      cmd_i = mk(2'd0, 1'b0, 16'h0ABC, 10'h155, 3'd5);
      rank_cmd_ready_i = 4'hF;
      step();
      check("full_pop_same_cycle", 64'(last_ready), 64'd0);
      step();
      check("full_pop_next_accept", 64'(last_ready), 64'd1);
      cmd_valid_i = 1'b0;
      for (int i = 0; i < FIFO_DEPTH + 1; i++) step();
      check("rank0_drained", 64'(rank_fifo_cnt_o[FCW-1:0]), 64'd0);

      // read-order sequence with interleaved writes
      seq_ranks = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
      seq_rd    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_ord   = '{2'd3, 2'd1, 2'd3, 2'd0};
      cmd_valid_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cmd_i = mk(seq_ranks[i], seq_rd[i], 16'(16'h200 + i), 10'(3 * i), 3'(i));
         step();
      end
      cmd_valid_i = 1'b0;
      rd_order_pop_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ord_seq%0d", i), 64'(rd_order_rank_o), 64'(exp_ord[i]));
         step();
      end
      rd_order_pop_i = 1'b0;

      // 16 unpopped reads fill the order queue
      cmd_valid_i = 1'b1;
      for (int i = 0; i < ORDER_DEPTH; i++) begin
         cmd_i = mk(2'(i), 1'b1, 16'(16'h300 + i), 10'(i), 3'(i));
         step();
      end
      cmd_i = mk(2'd2, 1'b1, 16'h0399, 10'h001, 3'd2);
      step();
      check("ord_full_read_refused", 64'(last_ready), 64'd0);
      cmd_i = mk(2'd2, 1'b0, 16'h039A, 10'h002, 3'd2);
      step();
      check("ord_full_write_ok", 64'(last_ready), 64'd1);
      cmd_valid_i = 1'b0;

      // drain, then pop while empty
      rd_order_pop_i = 1'b1;
      for (int i = 0; i < ORDER_DEPTH + 4; i++) step();
      check("empty_ord_cnt", 64'(rd_order_valid_o), 64'd0);
      check("empty_rank_cnts", 64'(rank_fifo_cnt_o), 64'd0);
      rd_order_pop_i = 1'b0;

      // reset mid-operation
      rank_cmd_ready_i = 4'h0;
      cmd_valid_i = 1'b1;
      cmd_i = mk(2'd1, 1'b1, 16'h0401, 10'h001, 3'd1); step();
      cmd_i = mk(2'd1, 1'b1, 16'h0402, 10'h002, 3'd1); step();
      cmd_i = mk(2'd1, 1'b0, 16'h0403, 10'h003, 3'd1); step();
      cmd_valid_i = 1'b0;
      check("pre_reset_rank1_cnt", 64'(rank_fifo_cnt_o[FCW +: FCW]), 64'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_reset_valids", 64'(rank_cmd_valid_o), 64'd0);
      check("mid_reset_ord", 64'(rd_order_valid_o), 64'd0);
      rank_cmd_ready_i = 4'hF;
      rd_order_pop_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      rd_order_pop_i = 1'b0;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cmd_valid_i = ($urandom_range(0, 3) != 0);
         cmd_i = {$urandom, $urandom} & {USER_W{1'b1}};
         rank_cmd_ready_i = 4'($urandom) & 4'($urandom);
         rd_order_pop_i = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
